serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL provide port clk, input, 1, single clock, all state updates on rising edge.
REQ-003 SHALL provide port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL provide port start, input, 1, request to begin an addition; sampled only when ready=1.
REQ-005 SHALL provide port a, input, WIDTH, operand A; captured on an accepted start.
REQ-006 SHALL provide port b, input, WIDTH, operand B; captured on an accepted start.
REQ-007 SHALL provide port cin, input, 1, carry-in; captured on an accepted start.
REQ-008 SHALL provide port ready, output, 1, high only in IDLE.
REQ-009 SHALL provide port busy, output, 1, high only in SHIFT.
REQ-010 SHALL provide port done, output, 1, single-cycle pulse in DONE.
REQ-011 SHALL provide port sum, output, WIDTH, registered result.
REQ-012 SHALL provide port cout, output, 1, registered final carry.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge:
- capture a, b and cin;
- clear the bit counter;
- enter SHIFT.
REQ-015 SHALL, in SHIFT, process one bit per cycle, LSB first, through one full-adder cell:
- carry flip-flop feeds the cell's carry-in;
- cell carry-out updates the carry flip-flop;
- cell sum bit shifts into an internal partial-sum register.
REQ-016 SHALL stay in SHIFT for exactly WIDTH edges, then enter DONE: done asserts WIDTH edges after the start-accepting edge.
REQ-017 SHALL load sum and cout from the partial-sum register and carry flip-flop on the SHIFT->DONE edge only; sum/cout SHALL NOT change during SHIFT.
REQ-018 SHALL hold sum/cout stable from DONE until the next SHIFT->DONE edge.
REQ-019 SHALL go from DONE to IDLE unconditionally after one cycle; start is ignored in SHIFT and DONE, with no queuing.
REQ-020 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), for all inputs.
REQ-021 SHALL ignore changes on a, b and cin after capture.

Reset
REQ-022 SHALL, on rst_n=0 at an edge, in any state including mid-SHIFT:
- enter IDLE;
- set sum=0, cout=0, done=0, busy=0, ready=1;
- clear the counter, carry and partial-sum registers.
REQ-023 SHALL give reset priority over start in the same cycle.

Configuration
REQ-024 SHALL, when SERIAL_ADD_OVF_EN is defined, add output ovf (1 bit):
- meaning: two's-complement signed overflow, i.e. the carry into the MSB XOR the carry out of the MSB;
- registered and held with sum;
- reset to 0.
REQ-025 SHALL, when SERIAL_ADD_OVF_EN is undefined, omit the ovf port and its logic entirely.

Structure
REQ-026 SHALL place the state encoding typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the counter-width function/constant in shared package serial_add_pkg.
REQ-027 SHALL instantiate one combinational sub-module fa_cell (ports a, b, cin, sum, carry) as the only arithmetic element.

Verification
REQ-028 SHALL check WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, done exactly 8 edges after start.
REQ-029 SHALL check a=0x55, b=0xAA, cin=1 -> sum=0x00, cout=1; a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
REQ-030 SHALL check that start pulsed during SHIFT and in DONE is ignored: a single done pulse, result of the first operands only.
REQ-031 SHALL check rst_n=0 after the 3rd SHIFT edge -> next cycle ready=1, busy=0, sum=0x00, cout=0; a new start then completes correctly.
REQ-032 SHALL check, with SERIAL_ADD_OVF_EN defined:
- a=0x7F, b=0x01 -> sum=0x80, ovf=1;
- a=0xFF, b=0x01 -> ovf=0.
REQ-033 SHALL check WIDTH=1 exhaustively over all 8 {a,b,cin} combinations -> {cout,sum} equals the arithmetic sum, done 1 edge after start.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and sizing helpers for the serial adder
// Purpose: FSM state encoding and bit-counter width helper shared by
//          serial_add_ctrl and its testbench.
// Ports:   none (package).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter runs 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// rtl/serial_add_ctrl_fa_cell.sv - single-bit full-adder cell
// Purpose: the only arithmetic element of the serial adder.
// Ports:   a, b, cin - input bits; sum, carry - combinational outputs.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller (IDLE/SHIFT/DONE)
// Purpose: captures a, b, cin on an accepted start and adds them one bit per
//          cycle, LSB first, through a single fa_cell; result is registered
//          on the SHIFT->DONE edge and held until the next one.
// Ports:   clk, rst_n (sync, active low), start, a, b, cin in;
//          ready (IDLE), busy (SHIFT), done (1-cycle pulse), sum, cout out;
//          ovf out only when SERIAL_ADD_OVF_EN is defined (signed overflow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry;
  logic             bit_sum;
  logic             bit_carry;

  fa_cell u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry),
    .sum   (bit_sum),
    .carry (bit_carry)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_psum_w1
      assign psum_next = bit_sum;
    end else begin : g_psum_wn
      assign psum_next = {bit_sum, psum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            psum  <= '0;
            state <= SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= bit_carry;
          psum  <= psum_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final bit: publish the completed result in the same edge.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= psum_next;
            cout  <= bit_carry;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB cell here.
            ovf   <= carry ^ bit_carry;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard testbench for serial_add_ctrl
// Purpose: drives directed vectors into a WIDTH=8 and a WIDTH=1 instance,
//          pushes hand-computed results into per-instance queues and checks
//          them from monitors when done pulses. ovf checks need SERIAL_ADD_OVF_EN.
// Ports:   none (top-level bench).
module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cin8 = 1'b0, ready8, busy8, done8, cout8;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       cin1 = 1'b0, ready1, busy1, done1, cout1;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8, ovf1;
`endif

  exp_t q8[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] hold8 = '0;
  logic [0:0] hold1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
    .cout(cout8), .ovf(ovf8)
`else
    .cout(cout8)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADD_OVF_EN
    .cout(cout1), .ovf(ovf1)
`else
    .cout(cout1)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  // Monitors: pop on every done pulse; sum must not move while busy.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) fail_now("unexpected_done8");
      else begin
        e = q8.pop_front();
        chk({e.name, "_sum"}, sum8, e.sum);
        chk({e.name, "_cout"}, cout8, e.cout);
        chk({e.name, "_lat"}, cyc, e.cyc);
`ifdef SERIAL_ADD_OVF_EN
        chk({e.name, "_ovf"}, ovf8, e.ovf);
`endif
      end
    end
    if (busy8) chk("sum8_stable", sum8, hold8);
    else hold8 = sum8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) fail_now("unexpected_done1");
      else begin
        e = q1.pop_front();
        chk({e.name, "_sum"}, sum1, e.sum);
        chk({e.name, "_cout"}, cout1, e.cout);
        chk({e.name, "_lat"}, cyc, e.cyc);
`ifdef SERIAL_ADD_OVF_EN
        chk({e.name, "_ovf"}, ovf1, e.ovf);
`endif
      end
    end
    if (busy1) chk("sum1_stable", sum1, hold1);
    else hold1 = sum1;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input string nm);
    exp_t e;
    int   n = 0;
    while (!ready8 && n < 50) begin @(negedge clk); n++; end
    if (!ready8) fail_now({nm, "_ready"});
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + 8; e.name = nm;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    // Scramble inputs after capture; result must not depend on them.
    a8 = ~ia; b8 = ib ^ 8'h5A; cin8 = ~ic;
  endtask

  task automatic issue1(input logic ia, input logic ib, input logic ic, input string nm);
    exp_t e;
    int   n = 0;
    logic [1:0] total;
    while (!ready1 && n < 50) begin @(negedge clk); n++; end
    if (!ready1) fail_now({nm, "_ready"});
    a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
    total = {1'b0, ia} + {1'b0, ib} + {1'b0, ic};
    e.sum = {7'b0, total[0]}; e.cout = total[1]; e.ovf = ic ^ total[1];
    e.cyc = cyc + 1 + 1; e.name = nm;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~ia; b1 = ~ib; cin1 = ~ic;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (q8.size() != 0 || q1.size() != 0) fail_now("drain");
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
    issue8(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, "55_aa_c");
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01");
    issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "80_80");
    issue8(8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0, "0f_01_c");
    drain();

    // start pulses during SHIFT and in DONE must be dropped.
    issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "12_34");
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin @(negedge clk); n++; end
    if (!done8) fail_now("wait_done");
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("ign_ready", ready8, 1);
    chk("ign_busy", busy8, 0);
    repeat (3) @(negedge clk);
    chk("ign_idle_ready", ready8, 1);
    chk("ign_held_sum", sum8, 8'h46);

    // Abort after the third SHIFT edge.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy8, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", ready8, 1);
    chk("abort_busy", busy8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    chk("abort_done", done8, 0);
    issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "post_rst");
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      issue1(v[2], v[1], v[0], $sformatf("w1_%0d", i));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
